gj_inverse_ctrl: RTL and testbench

Sequencer for the Gauss-Jordan matrix-inversion datapath operating on an N x N augmented matrix of signed Q16.16 words. For each column it performs a partial-pivot search, row swap, pivot normalisation (via an external reciprocal unit) and elimination of every other row. It issues row-operation commands to the row-op datapath and drives its element read port. Start/done handshake to the host.

---
 rtl/gj_pkg.sv | 34 +++
 rtl/gj_pivot_search.sv | 37 +++
 rtl/gj_inverse_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_gj_inverse_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gj_pkg.sv
// Shared constants for the Gauss-Jordan inversion sequencer: op codes,
// FSM state encodings, Q16.16 format and the saturating magnitude helper.
package gj_pkg;

    localparam int GJ_DATA_W = 32;
    localparam int FRAC_W    = 16;
    localparam logic [GJ_DATA_W-1:0] ONE = 32'h0001_0000;

    localparam logic [1:0] OP_SWAP  = 2'd0;
    localparam logic [1:0] OP_SCALE = 2'd1;
    localparam logic [1:0] OP_ELIM  = 2'd2;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SEARCH = 4'd1;
    localparam logic [3:0] S_CHECK  = 4'd2;
    localparam logic [3:0] S_SWAP   = 4'd3;
    localparam logic [3:0] S_DIV    = 4'd4;
    localparam logic [3:0] S_SCALE  = 4'd5;
    localparam logic [3:0] S_FACT   = 4'd6;
    localparam logic [3:0] S_ELIM   = 4'd7;
    localparam logic [3:0] S_NEXT   = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    // |x| with the most negative value clamped so the result stays positive
    function automatic logic [GJ_DATA_W-1:0] abs_sat(input logic [GJ_DATA_W-1:0] x);
        if (x == {1'b1, {(GJ_DATA_W-1){1'b0}}})
            return {1'b0, {(GJ_DATA_W-1){1'b1}}};
        else if (x[GJ_DATA_W-1])
            return -x;
        else
            return x;
    endfunction

endpackage

// File: rtl/gj_pivot_search.sv
// Running |max| / argmax over a column streamed one element per valid.
// Strict greater-than keeps the lowest row on ties; the signed value of
// the winner is kept too since the divider needs the pivot with its sign.
module gj_pivot_search
    import gj_pkg::*;
#(
    parameter int DATA_W = GJ_DATA_W,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] abs_max,
    output logic [IDX_W-1:0]  max_idx,
    output logic [DATA_W-1:0] max_val
);

    logic [DATA_W-1:0] mag;
    assign mag = abs_sat(data);

    // Track the largest magnitude seen since the last clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            abs_max <= '0;
            max_idx <= '0;
            max_val <= '0;
        end else if (valid && (mag > abs_max)) begin
            abs_max <= mag;
            max_idx <= idx;
            max_val <= data;
        end
    end

endmodule

// File: rtl/gj_inverse_ctrl.sv
// Gauss-Jordan inversion sequencer: per column does pivot search, row swap,
// pivot normalisation through an external reciprocal unit, and elimination
// of every other row, issuing row-op commands to the datapath.
module gj_inverse_ctrl
    import gj_pkg::*;
#(
    parameter int N      = 7,
    parameter int DATA_W = GJ_DATA_W,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              singular,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_row,
    output logic [IDX_W-1:0]  rd_col,
    input  logic [DATA_W-1:0] rd_data,
    output logic              div_start,
    output logic [DATA_W-1:0] div_operand,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_result,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [1:0]        op_code,
    output logic [IDX_W-1:0]  op_ra,
    output logic [IDX_W-1:0]  op_rb,
    output logic [DATA_W-1:0] op_coef
);

    // Row counter is one bit wider so it can reach N as the end marker
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] N_C    = CNT_W'(N);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

    logic [3:0]        state;
    logic [IDX_W-1:0]  k;
    logic [CNT_W-1:0]  r;
    logic [CNT_W-1:0]  k_ext;
    logic              rd_vld;
    logic [IDX_W-1:0]  rd_row_q;
    logic [DATA_W-1:0] recip;
    logic [DATA_W-1:0] factor;
    logic              div_issued;
    logic              search_clr;
    logic              search_vld;
    logic [DATA_W-1:0] abs_max;
    logic [IDX_W-1:0]  max_idx;
    logic [DATA_W-1:0] max_val;

    assign k_ext      = {1'b0, k};
    assign search_clr = ((state == S_IDLE) && start) || (state == S_NEXT);
    assign search_vld = rd_vld && (state == S_SEARCH);

    gj_pivot_search #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_search (
        .clk     (clk),
        .rst     (rst),
        .clear   (search_clr),
        .valid   (search_vld),
        .data    (rd_data),
        .idx     (rd_row_q),
        .abs_max (abs_max),
        .max_idx (max_idx),
        .max_val (max_val)
    );

    // Read strobes: a burst down column k in SEARCH, one row at a time in FACT
    always_comb begin
        rd_en = 1'b0;
        if (state == S_SEARCH)
            rd_en = (r < N_C);
        else if (state == S_FACT)
            rd_en = !rd_vld && (r < N_C) && (r != k_ext);
        rd_row = rd_en ? r[IDX_W-1:0] : '0;
        rd_col = rd_en ? k : '0;
    end

    // Status, divider request and row-op command decode
    always_comb begin
        busy        = (state != S_IDLE) && (state != S_DONE);
        done        = (state == S_DONE);
        div_start   = (state == S_DIV) && !div_issued;
        div_operand = (state == S_DIV) ? max_val : '0;
        op_valid    = 1'b0;
        op_code     = OP_SWAP;
        op_ra       = '0;
        op_rb       = '0;
        op_coef     = '0;
        case (state)
            S_SWAP:  begin op_valid = 1'b1; op_code = OP_SWAP;  op_ra = k; op_rb = max_idx; end
            S_SCALE: begin op_valid = 1'b1; op_code = OP_SCALE; op_ra = k; op_coef = recip; end
            S_ELIM:  begin
                op_valid = 1'b1;
                op_code  = OP_ELIM;
                op_ra    = r[IDX_W-1:0];
                op_rb    = k;
                op_coef  = factor;
            end
            default: ;
        endcase
    end

    // Remember which row a read targeted so the returning data can be tagged
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld   <= 1'b0;
            rd_row_q <= '0;
        end else begin
            rd_vld   <= rd_en;
            rd_row_q <= rd_row;
        end
    end

    // Main sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= '0;
            r          <= '0;
            recip      <= '0;
            factor     <= '0;
            singular   <= 1'b0;
            div_issued <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_SEARCH;
                    k        <= '0;
                    r        <= '0;
                    singular <= 1'b0;
                end
                // Final cycle (r == N) only absorbs the last returning element
                S_SEARCH: if (r == N_C) state <= S_CHECK;
                          else          r     <= r + 1'b1;
                S_CHECK: begin
                    if (abs_max == '0) begin
                        singular <= 1'b1;
                        state    <= S_DONE;
                    end else if (max_idx != k) begin
                        state <= S_SWAP;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_SWAP: if (op_ready) state <= S_DIV;
                S_DIV: begin
                    div_issued <= 1'b1;
                    if (div_issued && div_done) begin
                        recip      <= div_result;
                        div_issued <= 1'b0;
                        state      <= S_SCALE;
                    end
                end
                S_SCALE: if (op_ready) begin
                    state <= S_FACT;
                    r     <= '0;
                end
                // Alternates issue/evaluate; zero factors need no row op
                S_FACT: begin
                    if (rd_vld) begin
                        if (rd_data == '0) begin
                            r <= r + 1'b1;
                        end else begin
                            factor <= rd_data;
                            state  <= S_ELIM;
                        end
                    end else if (r == N_C) begin
                        state <= S_NEXT;
                    end else if (r == k_ext) begin
                        r <= r + 1'b1;
                    end
                end
                S_ELIM: if (op_ready) begin
                    r     <= r + 1'b1;
                    state <= S_FACT;
                end
                S_NEXT: begin
                    if (k == K_LAST) begin
                        state <= S_DONE;
                    end else begin
                        k     <= k + 1'b1;
                        r     <= k_ext + 1'b1;
                        state <= S_SEARCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gj_inverse_ctrl.sv
// Directed bench for gj_inverse_ctrl: a behavioural row-op datapath and
// reciprocal unit surround the sequencer; op streams are logged and
// compared against hand-worked Gauss-Jordan sequences.
module tb_gj_inverse_ctrl;
    import gj_pkg::*;

    localparam int N = 7;

    logic        clk, rst, start, busy, done, singular, rd_en;
    logic [2:0]  rd_row, rd_col, op_ra, op_rb;
    logic [31:0] rd_data, div_operand, div_result, op_coef;
    logic        div_start, div_done, op_valid, op_ready;
    logic [1:0]  op_code;

    gj_inverse_ctrl #(.N(N), .DATA_W(32), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .singular(singular), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .div_start(div_start), .div_operand(div_operand),
        .div_done(div_done), .div_result(div_result), .op_valid(op_valid),
        .op_ready(op_ready), .op_code(op_code), .op_ra(op_ra), .op_rb(op_rb),
        .op_coef(op_coef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mat    [0:7][0:7];
    logic [31:0] init_m [0:7][0:7];
    logic        load;
    logic [39:0] log_op [0:127];
    logic [31:0] div_log[0:127];
    int          op_cnt = 0;
    int          div_cnt = 0;
    int          done_cnt = 0;
    int          div_lat;
    int          dcnt;
    logic [31:0] dop;
    bit          stall_elim;
    bit          poke;

    function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 32'(p >>> FRAC_W);
    endfunction

    // Behavioural datapath: registered element read and row operations
    always @(posedge clk) begin
        if (load)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++) mat[i][j] <= init_m[i][j];
        if (rd_en) rd_data <= mat[rd_row][rd_col];
        if (op_valid && op_ready) begin
            log_op[op_cnt[6:0]] <= {op_code, op_ra, op_rb, op_coef};
            op_cnt <= op_cnt + 1;
            for (int j = 0; j < N; j++) begin
                case (op_code)
                    OP_SWAP:  begin mat[op_ra][j] <= mat[op_rb][j]; mat[op_rb][j] <= mat[op_ra][j]; end
                    OP_SCALE: mat[op_ra][j] <= q_mul(op_coef, mat[op_ra][j]);
                    OP_ELIM:  mat[op_ra][j] <= mat[op_ra][j] - q_mul(op_coef, mat[op_rb][j]);
                    default: ;
                endcase
            end
        end
        if (div_start) begin
            div_log[div_cnt[6:0]] <= div_operand;
            div_cnt <= div_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Reciprocal unit with programmable latency
    always @(posedge clk) begin
        if (rst)                dcnt <= 0;
        else if (div_start) begin dcnt <= div_lat; dop <= div_operand; end
        else if (dcnt != 0)     dcnt <= dcnt - 1;
    end
    assign div_done   = (dcnt == 1);
    assign div_result = (dop == 32'd0) ? 32'd0 :
                        32'((longint'(1) <<< 32) / longint'($signed(dop)));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Compare a logged op, ignoring fields the op code leaves undefined
    task automatic chk_op(input string tag, input int idx, input logic [1:0] code,
                          input logic [2:0] ra, input logic [2:0] rb, input logic [31:0] coef);
        logic [39:0] g, e;
        g = log_op[idx[6:0]];
        e = {code, ra, rb, coef};
        if (code == OP_SWAP)  begin g[31:0]  = '0; e[31:0]  = '0; end
        if (code == OP_SCALE) begin g[34:32] = '0; e[34:32] = '0; end
        chk(tag, 64'(g), 64'(e));
    endtask

    task automatic load_identity();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) init_m[i][j] = (i == j && i < N) ? ONE : 32'd0;
    endtask

    task automatic push_matrix();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"}, 64'({busy, done, singular, rd_en, div_start, op_valid}), 64'd0);
        chk({tag, "_dat"}, {rd_row, rd_col, op_ra, op_rb, op_code, op_coef[20:0]}, 64'd0);
        chk({tag, "_div"}, 64'({div_operand, op_coef}), 64'd0);
    endtask

    // Pulse start and wait (bounded) for the done pulse
    task automatic run(input string tag, input int budget);
        int c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_sing_clr"}, 64'(singular), 64'd0);
        c = 0;
        while (!done && c < budget) begin
            if (stall_elim && op_valid && op_code == OP_ELIM) begin
                op_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk({tag, "_stall"}, 64'({op_valid, op_code, op_ra, op_rb, op_coef}),
                        64'({1'b1, OP_ELIM, 3'd1, 3'd0, 32'h0001_0000}));
                end
                op_ready   = 1'b1;
                stall_elim = 1'b0;
            end
            start = (poke && c == 30);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    int base;

    initial begin
        rst = 1'b1; start = 1'b0; op_ready = 1'b1; div_lat = 1; load = 1'b0;
        stall_elim = 1'b0; poke = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;

        // Identity: one unit SCALE per column, nothing else
        load_identity(); push_matrix();
        base = op_cnt;
        run("ident", 2000);
        chk("ident_sing", 64'(singular), 64'd0);
        chk("ident_nops", 64'(op_cnt - base), 64'd7);
        for (int i = 0; i < 7; i++) chk_op("ident_op", base + i, OP_SCALE, 3'(i), 3'd0, ONE);

        // Pivot swap, negative pivot, elimination, with an ELIM back-pressured
        load_identity();
        init_m[0][0] = 32'd0; init_m[0][1] = ONE;
        init_m[1][0] = ONE;   init_m[1][1] = ONE;
        init_m[2][0] = 32'hFFFE_0000; init_m[2][2] = ONE;
        push_matrix();
        base = op_cnt;
        stall_elim = 1'b1;
        run("swap", 2000);
        chk("swap_sing", 64'(singular), 64'd0);
        chk("swap_nops", 64'(op_cnt - base), 64'd12);
        chk_op("swap_op0", base + 0, OP_SWAP,  3'd0, 3'd2, 32'd0);
        chk("swap_divop", 64'(div_log[(div_cnt - 7) & 127]), 64'h0000_0000_FFFE_0000);
        chk_op("swap_op1", base + 1, OP_SCALE, 3'd0, 3'd0, 32'hFFFF_8000);
        chk_op("swap_op2", base + 2, OP_ELIM,  3'd1, 3'd0, ONE);
        chk_op("swap_op4", base + 4, OP_ELIM,  3'd2, 3'd1, ONE);
        chk_op("swap_op5", base + 5, OP_SCALE, 3'd2, 3'd0, 32'hFFFE_0000);
        chk_op("swap_op6", base + 6, OP_ELIM,  3'd0, 3'd2, 32'hFFFF_8000);
        chk_op("swap_op7", base + 7, OP_ELIM,  3'd1, 3'd2, 32'h0000_8000);

        // Zero column 3 -> singular after three SCALEs
        load_identity(); init_m[3][3] = 32'd0; push_matrix();
        base = op_cnt;
        run("sing", 2000);
        chk("sing_flag", 64'(singular), 64'd1);
        repeat (10) @(negedge clk);
        chk("sing_nops", 64'(op_cnt - base), 64'd3);
        chk("sing_hold", 64'({singular, busy}), 64'b10);

        // Tie at rows 1 and 4: lowest row wins
        load_identity();
        init_m[0][0] = 32'd0; init_m[1][0] = 32'h0002_0000; init_m[4][0] = 32'h0002_0000;
        push_matrix();
        base = op_cnt;
        run("tie", 3000);
        chk_op("tie_op0", base + 0, OP_SWAP,  3'd0, 3'd1, 32'd0);
        chk_op("tie_op1", base + 1, OP_SCALE, 3'd0, 3'd0, 32'h0000_8000);

        // Reset while waiting on the divider
        load_identity(); push_matrix();
        div_lat = 200;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int c = 0; c < 50 && !div_start; c++) @(negedge clk);
        chk("rst_divwait", 64'(div_start), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outs("midrst");
        rst = 1'b0;
        div_lat = 1;
        load_identity(); push_matrix();
        base = op_cnt;
        poke = 1'b1;
        run("rerun", 2000);
        poke = 1'b0;
        chk("rerun_sing", 64'(singular), 64'd0);
        repeat (5) @(negedge clk);
        chk("rerun_nops", 64'(op_cnt - base), 64'd7);
        chk("rerun_idle", 64'(busy), 64'd0);
        chk_op("rerun_op6", base + 6, OP_SCALE, 3'd6, 3'd0, ONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
